cordic_vectoring_iterative: RTL and testbench

//  Iterative CORDIC in vectoring mode, circular coordinates: converts a signed Cartesian

---
 rtl/cordic_vectoring_iterative_pkg.sv | 66 ++++++
 rtl/cordic_vectoring_iterative_slice.sv | 36 +++
 rtl/cordic_vectoring_iterative.sv | 180 ++++++++++++++++++
 tb/tb_cordic_vectoring_iterative.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cordic_vectoring_iterative_pkg.sv
// Shared types and constant helpers for the iterative vectoring CORDIC.
package cordic_vectoring_iterative_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Product of sqrt(1+2^-2i) over the micro-rotations; magnitude output carries this gain.
  localparam real CORDIC_GAIN = 1.6467602581;

  // Ceiling log2, for constant expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // +pi/2 in an aw-bit binary angle (full scale 2^(aw-1) = pi).
  function automatic int pi_half(input int aw);
    return 1 << (aw - 2);
  endfunction

  // round(atan(2^-i)/pi * 2^(aw-1)); base table holds the value scaled by 2^24.
  // Valid for aw <= 25; entries beyond the table round to zero at those widths.
  function automatic int atan_value(input int i, input int aw);
    longint t;
    int     sh;
    case (i)
      0:  t = 4194304;
      1:  t = 2476042;
      2:  t = 1308273;
      3:  t = 664100;
      4:  t = 333339;
      5:  t = 166832;
      6:  t = 83436;
      7:  t = 41721;
      8:  t = 20861;
      9:  t = 10430;
      10: t = 5215;
      11: t = 2608;
      12: t = 1304;
      13: t = 652;
      14: t = 326;
      15: t = 163;
      16: t = 81;
      17: t = 41;
      18: t = 20;
      19: t = 10;
      20: t = 5;
      21: t = 3;
      22: t = 1;
      23: t = 1;
      default: t = 0;
    endcase
    sh = 25 - aw;
    if (sh <= 0) return int'(t <<< (-sh));
    return int'((t + (longint'(1) <<< (sh - 1))) >>> sh);
  endfunction

endpackage

// File: rtl/cordic_vectoring_iterative_slice.sv
// One combinational vectoring micro-rotation: drives Y toward zero, accumulates angle in Z.
module cordic_vectoring_iterative_slice #(
  parameter int XW = 12,
  parameter int AW = 10,
  parameter int SW = 4
) (
  input  logic signed [XW-1:0] x_i,
  input  logic signed [XW-1:0] y_i,
  input  logic signed [AW-1:0] z_i,
  input  logic        [SW-1:0] shift_i,
  input  logic signed [AW-1:0] atan_i,
  output logic signed [XW-1:0] x_o,
  output logic signed [XW-1:0] y_o,
  output logic signed [AW-1:0] z_o,
  output logic                 dir_o
);

  logic signed [XW-1:0] xs, ys;

  // Rotate clockwise when Y is non-negative, counter-clockwise otherwise.
  always_comb begin
    xs    = x_i >>> shift_i;
    ys    = y_i >>> shift_i;
    dir_o = ~y_i[XW-1];
    if (dir_o) begin
      x_o = x_i + ys;
      y_o = y_i - xs;
      z_o = z_i + atan_i;
    end else begin
      x_o = x_i - ys;
      y_o = y_i + xs;
      z_o = z_i - atan_i;
    end
  end

endmodule

// File: rtl/cordic_vectoring_iterative.sv
// Iterative vectoring CORDIC: (X,Y) -> (K*|v|, atan2) with one micro-rotation per clock.
module cordic_vectoring_iterative
  import cordic_vectoring_iterative_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int GUARD_W = 2,
  parameter int N_ITER  = DATA_W + GUARD_W
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     strb_data_valid_i,
  input  logic signed [DATA_W-1:0] X_i,
  input  logic signed [DATA_W-1:0] Y_i,
  output logic        [DATA_W:0]   MAG_o,
  output logic signed [DATA_W-1:0] ANGLE_o,
  output logic                     busy_o,
  output logic                     strb_data_valid_o
);

  localparam int XW = DATA_W + 2 + GUARD_W;
  localparam int AW = DATA_W + GUARD_W;
  localparam int CW = clog2(N_ITER + 1);

  localparam logic signed [AW-1:0] PI_HALF = AW'(pi_half(AW));
  localparam logic signed [AW-1:0] ANG_RND = AW'(1 << (GUARD_W - 1));

  state_e                     state_q, state_d;
  logic        [CW-1:0]       cnt_q, cnt_d;
  logic signed [DATA_W-1:0]   xin_q, xin_d, yin_q, yin_d;
  logic                       zero_q, zero_d;
  logic signed [XW-1:0]       x_q, x_d, y_q, y_d;
  logic signed [AW-1:0]       z_q, z_d;
  logic        [DATA_W:0]     mag_q, mag_d;
  logic signed [DATA_W-1:0]   ang_q, ang_d;
  logic                       busy_q, busy_d;
  logic                       vld_q, vld_d;

  logic [N_ITER-1:0][AW-1:0]  atan_tbl;
  logic signed [AW-1:0]       atan_sel;
  logic signed [XW-1:0]       x_n, y_n, xe, ye;
  logic signed [AW-1:0]       z_n, z_rnd;
  logic                       dir_n;

  // Elaboration-time arctangent table, one entry per shift amount.
  for (genvar g = 0; g < N_ITER; g++) begin : g_atan
    assign atan_tbl[g] = AW'(atan_value(g, AW));
  end

  // Past the last iteration the selected angle is forced to zero.
  always_comb begin
    atan_sel = '0;
    if (cnt_q < CW'(N_ITER)) atan_sel = signed'(atan_tbl[cnt_q]);
  end

  cordic_vectoring_iterative_slice #(
    .XW (XW),
    .AW (AW),
    .SW (CW)
  ) u_slice (
    .x_i     (x_q),
    .y_i     (y_q),
    .z_i     (z_q),
    .shift_i (cnt_q),
    .atan_i  (atan_sel),
    .x_o     (x_n),
    .y_o     (y_n),
    .z_o     (z_n),
    .dir_o   (dir_n)
  );

  // Next-state logic: a strobe always wins and restarts from PRE, aborting any conversion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xin_d   = xin_q;
    yin_d   = yin_q;
    zero_d  = zero_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    mag_d   = mag_q;
    ang_d   = ang_q;
    vld_d   = 1'b0;
    xe      = XW'(xin_q) <<< GUARD_W;
    ye      = XW'(yin_q) <<< GUARD_W;
    z_rnd   = z_n + ANG_RND;

    case (state_q)
      ST_PRE: begin
        // Fold the vector into the right half-plane so the iterations converge.
        if (!xe[XW-1]) begin
          x_d = xe;
          y_d = ye;
          z_d = '0;
        end else if (!ye[XW-1]) begin
          x_d = ye;
          y_d = -xe;
          z_d = PI_HALF;
        end else begin
          x_d = -ye;
          y_d = xe;
          z_d = -PI_HALF;
        end
        cnt_d   = '0;
        state_d = ST_ITER;
      end
      ST_ITER: begin
        x_d = x_n;
        y_d = y_n;
        z_d = z_n;
        if (cnt_q == CW'(N_ITER - 1)) begin
          state_d = ST_DONE;
          vld_d   = 1'b1;
          if (zero_q) begin
            mag_d = '0;
            ang_d = '0;
          end else begin
            // X is non-negative after the fold, so dropping the sign bit is safe.
            mag_d = (DATA_W + 1)'(x_n >>> GUARD_W);
            ang_d = DATA_W'(z_rnd >>> GUARD_W);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (strb_data_valid_i) begin
      xin_d   = X_i;
      yin_d   = Y_i;
      zero_d  = (X_i == '0) && (Y_i == '0);
      cnt_d   = '0;
      state_d = ST_PRE;
      vld_d   = 1'b0;
      mag_d   = mag_q;
      ang_d   = ang_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // All state and registered outputs, with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      xin_q   <= '0;
      yin_q   <= '0;
      zero_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      mag_q   <= '0;
      ang_q   <= '0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xin_q   <= xin_d;
      yin_q   <= yin_d;
      zero_q  <= zero_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      mag_q   <= mag_d;
      ang_q   <= ang_d;
      busy_q  <= busy_d;
      vld_q   <= vld_d;
    end
  end

  assign MAG_o             = mag_q;
  assign ANGLE_o           = ang_q;
  assign busy_o            = busy_q;
  assign strb_data_valid_o = vld_q;

endmodule

// File: tb/tb_cordic_vectoring_iterative.sv
// Randomized bench for the vectoring CORDIC against an atan2/hypot reference model.
module tb_cordic_vectoring_iterative;
  import cordic_vectoring_iterative_pkg::*;

  localparam real PI_R    = 3.14159265358979;
  localparam int  LAT     = 12;
  localparam int  N_RAND  = 2000;

  logic                    clk = 1'b0;
  logic                    rstn = 1'b0;
  logic                    strb = 1'b0;
  logic signed [7:0]       xi = '0;
  logic signed [7:0]       yi = '0;
  logic        [8:0]       mag;
  logic signed [7:0]       ang;
  logic                    busy;
  logic                    vld;

  cordic_vectoring_iterative #(
    .DATA_W  (8),
    .GUARD_W (2)
  ) dut (
    .clk_i             (clk),
    .rstn_i            (rstn),
    .strb_data_valid_i (strb),
    .X_i               (xi),
    .Y_i               (yi),
    .MAG_o             (mag),
    .ANGLE_o           (ang),
    .busy_o            (busy),
    .strb_data_valid_o (vld)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int x;
    int y;
    int c;
    bit lit;
    int lit_m;
    int lit_a;
  } conv_t;

  conv_t q[$];
  int    last_x = 0;
  int    last_y = 0;
  int    n_vec  = 0;
  int    n_chk  = 0;
  int    n_err  = 0;
  bit    chk_en = 1'b0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic real rabs(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  function automatic real wrap_r(input real d);
    real r;
    r = d;
    while (r > 128.0)  r = r - 256.0;
    while (r < -128.0) r = r + 256.0;
    return r;
  endfunction

  function automatic int wrap_i(input int d);
    return (((d % 256) + 256 + 128) % 256) - 128;
  endfunction

  // Reference: magnitude K*hypot, angle atan2 in units of pi/128; zero vector is exact zero.
  task automatic check_vals(input int x, input int y, input string tag);
    real em, ea, d;
    if (x == 0 && y == 0) begin
      chk(mag == 0, {tag, " mag(zero)"}, int'(mag), 0);
      chk(ang == 0, {tag, " angle(zero)"}, int'(ang), 0);
    end else begin
      em = CORDIC_GAIN * $sqrt(real'(x * x + y * y));
      ea = $atan2(real'(y), real'(x)) / PI_R * 128.0;
      chk(rabs(real'(mag) - em) <= 3.0, {tag, " mag"}, int'(mag), $rtoi(em + 0.5));
      d = wrap_r(real'(ang) - ea);
      chk(rabs(d) <= 2.0, {tag, " angle"}, int'(ang), $rtoi(ea + ((ea < 0.0) ? -0.5 : 0.5)));
    end
  endtask

  // Single compare process: busy, pulse timing and output values every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      bit    eb;
      conv_t cur;
      eb = 1'b0;
      foreach (q[i]) if (cyc >= q[i].c + 1 && cyc <= q[i].c + LAT) eb = 1'b1;
      chk(busy === eb, "busy", int'(busy), int'(eb));
      while (q.size() >= 2 && q[1].c < q[0].c + LAT) void'(q.pop_front());
      if (q.size() > 0 && cyc == q[0].c + LAT) begin
        cur = q.pop_front();
        chk(vld === 1'b1, "pulse", int'(vld), 1);
        last_x = cur.x;
        last_y = cur.y;
        check_vals(cur.x, cur.y, "result");
        if (cur.lit) begin
          chk((int'(mag) - cur.lit_m) <= 2 && (cur.lit_m - int'(mag)) <= 2,
              "literal mag", int'(mag), cur.lit_m);
          chk(wrap_i(int'(ang) - cur.lit_a) <= 1 && wrap_i(int'(ang) - cur.lit_a) >= -1,
              "literal angle", int'(ang), cur.lit_a);
        end
      end else begin
        chk(vld === 1'b0, "no pulse", int'(vld), 0);
        check_vals(last_x, last_y, "hold");
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int x, input int y, input bit lit, input int lm, input int la);
    conv_t e;
    xi     = 8'(x);
    yi     = 8'(y);
    strb   = 1'b1;
    e.x    = x;
    e.y    = y;
    e.c    = cyc;
    e.lit  = lit;
    e.lit_m = lm;
    e.lit_a = la;
    q.push_back(e);
    n_vec++;
    @(posedge clk);
    #1;
    strb = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    q.delete();
    last_x = 0;
    last_y = 0;
  endtask

  initial begin
    int x, y, gap;
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    idle(2);
    rstn = 1'b1;
    idle(2);

    // Directed vectors with hand-computed results.
    strobe(100, 0, 1'b1, 165, 0);      idle(LAT + 1);
    strobe(0, 100, 1'b1, 165, 64);     idle(LAT + 1);
    strobe(-100, -100, 1'b1, 233, -96); idle(LAT + 1);
    strobe(-128, 0, 1'b1, 211, 128);   idle(LAT + 1);
    strobe(0, 0, 1'b1, 0, 0);          idle(LAT + 1);

    // Restart while busy: only the second vector is published.
    strobe(100, 0, 1'b0, 0, 0);        idle(4);
    strobe(0, -100, 1'b1, 165, -64);   idle(LAT + 1);

    // Reset in the middle of a conversion.
    strobe(50, -70, 1'b0, 0, 0);       idle(5);
    do_reset();                        idle(LAT + 2);

    // New strobe exactly in the DONE cycle.
    strobe(30, 40, 1'b0, 0, 0);        idle(LAT - 1);
    strobe(-60, 20, 1'b0, 0, 0);       idle(LAT + 1);

    // Random sweep, mostly back-to-back with occasional early restarts.
    for (int k = 0; k < N_RAND; k++) begin
      do begin
        x = int'($urandom_range(0, 255)) - 128;
        y = int'($urandom_range(0, 255)) - 128;
      end while (x * x + y * y < 576);
      gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 14)) : LAT;
      strobe(x, y, 1'b0, 0, 0);
      idle(gap - 1);
    end
    idle(LAT + 3);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
